// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-redirect and pipeline-control unit.
// Turns ID hazards, memory-stage ready and EXE branch resolution into the
// fetch stage's freeze / is_branch / flush / branch_address controls.
// A taken branch is captured into a pending register, issued as a
// one-cycle REDIRECT, then followed by SQUASH cycles so that flush is
// held for FLUSH_CYCLES cycles in total.
// Optional feature macro: FETCH_CTRL_STATS_EN adds saturating
// stall_cycles / redirect_count outputs; control behaviour is unchanged.
module fetch_ctrl #(
   parameter int ADDR_W       = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hazard,
   input  logic              mem_ready,
   input  logic              exe_branch_taken,
   input  logic [ADDR_W-1:0] exe_branch_address,
   output logic              freeze,
   output logic              is_branch,
   output logic              flush,
   output logic [ADDR_W-1:0] branch_address,
   output logic              pending
`ifdef FETCH_CTRL_STATS_EN
   ,
   output logic [15:0]       stall_cycles,
   output logic [15:0]       redirect_count
`endif
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_REDIRECT,
      ST_SQUASH
   } state_t;

   localparam logic [3:0] SQ_INIT = 4'(FLUSH_CYCLES - 1);

   state_t            state_q, state_d;
   logic              pend_valid_q, pend_valid_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic [ADDR_W-1:0] branch_address_q, branch_address_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              is_branch_q, is_branch_d;
   logic              flush_q, flush_d;
   logic              redirect_exit;

   // Next-state, pending capture, redirect issue and combinational freeze.
   always_comb begin
      state_d          = state_q;
      pend_valid_d     = pend_valid_q;
      pend_addr_d      = pend_addr_q;
      branch_address_d = branch_address_q;
      cnt_d            = cnt_q;
      freeze           = ~mem_ready;
      redirect_exit    = 1'b0;
      case (state_q)
         ST_RUN: begin
            freeze = hazard | ~mem_ready;
            // A branch arriving with nothing pending may issue on the same
            // edge it is captured; a held branch is never re-captured.
            if (mem_ready && (pend_valid_q || exe_branch_taken)) begin
               branch_address_d = pend_valid_q ? pend_addr_q : exe_branch_address;
               pend_valid_d     = 1'b0;
               state_d          = ST_REDIRECT;
            end else if (exe_branch_taken && !pend_valid_q) begin
               pend_valid_d = 1'b1;
               pend_addr_d  = exe_branch_address;
            end
         end
         ST_REDIRECT: begin
            if (mem_ready) begin
               redirect_exit = 1'b1;
               if (FLUSH_CYCLES == 1) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_SQUASH;
                  cnt_d   = SQ_INIT;
               end
            end
         end
         ST_SQUASH: begin
            if (mem_ready) begin
               if (cnt_q <= 4'd1) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         default: state_d = ST_RUN;
      endcase
      is_branch_d = (state_d == ST_REDIRECT);
      flush_d     = (state_d != ST_RUN);
   end

   // Control state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_RUN;
         pend_valid_q     <= 1'b0;
         pend_addr_q      <= '0;
         branch_address_q <= '0;
         cnt_q            <= '0;
         is_branch_q      <= 1'b0;
         flush_q          <= 1'b0;
      end else begin
         state_q          <= state_d;
         pend_valid_q     <= pend_valid_d;
         pend_addr_q      <= pend_addr_d;
         branch_address_q <= branch_address_d;
         cnt_q            <= cnt_d;
         is_branch_q      <= is_branch_d;
         flush_q          <= flush_d;
      end
   end

   assign is_branch      = is_branch_q;
   assign flush          = flush_q;
   assign branch_address = branch_address_q;
   assign pending        = pend_valid_q;

`ifdef FETCH_CTRL_STATS_EN
   logic [15:0] stall_cycles_q, stall_cycles_d;
   logic [15:0] redirect_count_q, redirect_count_d;

   // Saturating statistics counters.
   always_comb begin
      stall_cycles_d   = stall_cycles_q;
      redirect_count_d = redirect_count_q;
      if (freeze && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 16'd1;
      if (redirect_exit && (redirect_count_q != '1)) redirect_count_d = redirect_count_q + 16'd1;
   end

   // Statistics registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_q   <= '0;
         redirect_count_q <= '0;
      end else begin
         stall_cycles_q   <= stall_cycles_d;
         redirect_count_q <= redirect_count_d;
      end
   end

   assign stall_cycles   = stall_cycles_q;
   assign redirect_count = redirect_count_q;
`else
   logic unused_redirect_exit;
   assign unused_redirect_exit = redirect_exit;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: the stimulus process drives inputs and
// pushes the expected per-cycle outputs from a flush-countdown model; the
// monitor pops and compares at each falling edge.
module tb_fetch_ctrl;

   localparam int FC = 2;

   logic        clk;
   logic        rst;
   logic        hazard;
   logic        mem_ready;
   logic        exe_branch_taken;
   logic [31:0] exe_branch_address;
   logic        freeze;
   logic        is_branch;
   logic        flush;
   logic [31:0] branch_address;
   logic        pending;
`ifdef FETCH_CTRL_STATS_EN
   logic [15:0] stall_cycles;
   logic [15:0] redirect_count;
`endif

   fetch_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(FC)) dut (
      .clk                (clk),
      .rst                (rst),
      .hazard             (hazard),
      .mem_ready          (mem_ready),
      .exe_branch_taken   (exe_branch_taken),
      .exe_branch_address (exe_branch_address),
      .freeze             (freeze),
      .is_branch          (is_branch),
      .flush              (flush),
      .branch_address     (branch_address),
      .pending            (pending)
`ifdef FETCH_CTRL_STATS_EN
      ,
      .stall_cycles       (stall_cycles),
      .redirect_count     (redirect_count)
`endif
   );

   typedef struct {
      logic        freeze;
      logic        is_branch;
      logic        flush;
      logic [31:0] baddr;
      logic        pending;
      int          stall;
      int          redir;
   } exp_t;

   exp_t expq[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: flush cycles remaining, pending branch, counters.
   bit          m_pend;
   logic [31:0] m_paddr;
   logic [31:0] m_baddr;
   int          m_left;
   bit          m_first;
   int          m_stall;
   int          m_redir;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
      end
   endtask

   task automatic model_reset();
      m_pend  = 1'b0;
      m_paddr = '0;
      m_baddr = '0;
      m_left  = 0;
      m_first = 1'b0;
      m_stall = 0;
      m_redir = 0;
   endtask

   // Drive one cycle's inputs, record expected outputs, advance the model.
   task automatic step_body(input bit h, input bit m, input bit t, input logic [31:0] a);
      exp_t e;
      bit   run;
      hazard             = h;
      mem_ready          = m;
      exe_branch_taken   = t;
      exe_branch_address = a;
      run         = (m_left == 0);
      e.freeze    = run ? (h | ~m) : ~m;
      e.is_branch = m_first;
      e.flush     = !run;
      e.baddr     = m_baddr;
      e.pending   = m_pend;
      e.stall     = m_stall;
      e.redir     = m_redir;
      expq.push_back(e);
      if (e.freeze && m_stall < 65535) m_stall++;
      if (run) begin
         if (m && (m_pend || t)) begin
            m_baddr = m_pend ? m_paddr : a;
            m_pend  = 1'b0;
            m_left  = FC;
            m_first = 1'b1;
         end else if (t && !m_pend) begin
            m_pend  = 1'b1;
            m_paddr = a;
         end
      end else if (m) begin
         if (m_first && m_redir < 65535) m_redir++;
         m_left--;
         m_first = 1'b0;
      end
   endtask

   task automatic cycle(input bit h, input bit m, input bit t, input logic [31:0] a);
      @(posedge clk);
      #1;
      step_body(h, m, t, a);
   endtask

   // Asynchronous reset asserted mid-cycle, checked before the next edge.
   task automatic mid_reset();
      @(posedge clk);
      #1;
      hazard           = 1'b1;
      mem_ready        = 1'b1;
      exe_branch_taken = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("rst_flush", flush, 1'b0);
      check("rst_is_branch", is_branch, 1'b0);
      check("rst_pending", pending, 1'b0);
      check("rst_branch_address", branch_address, 32'h0);
      check("rst_freeze_run_eq", freeze, 1'b1);
`ifdef FETCH_CTRL_STATS_EN
      check("rst_stall_cycles", stall_cycles, 32'h0);
      check("rst_redirect_count", redirect_count, 32'h0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      step_body(1'b1, 1'b1, 1'b0, 32'h0);
   endtask

   // Monitor: compare DUT outputs against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            check("freeze", freeze, e.freeze);
            check("is_branch", is_branch, e.is_branch);
            check("flush", flush, e.flush);
            check("branch_address", branch_address, e.baddr);
            check("pending", pending, e.pending);
`ifdef FETCH_CTRL_STATS_EN
            check("stall_cycles", stall_cycles, 32'(e.stall));
            check("redirect_count", redirect_count, 32'(e.redir));
`endif
         end
      end
   end

   // Stimulus.
   initial begin
      rst                = 1'b1;
      hazard             = 1'b0;
      mem_ready          = 1'b1;
      exe_branch_taken   = 1'b0;
      exe_branch_address = '0;
      model_reset();
      @(posedge clk);
      #2;
      check("init_flush", flush, 1'b0);
      check("init_is_branch", is_branch, 1'b0);
      check("init_pending", pending, 1'b0);
      check("init_branch_address", branch_address, 32'h0);
      check("init_freeze", freeze, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step_body(1'b0, 1'b1, 1'b0, 32'h0);

      // Branch in RUN.
      cycle(1'b0, 1'b1, 1'b1, 32'h0000_0040);
      repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0);

      // Hazard only for three cycles.
      repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);
      repeat (2) cycle(1'b0, 1'b1, 1'b0, 32'h0);

      // Branch held through a four-cycle memory stall, then wrong-path branch.
      repeat (4) cycle(1'b0, 1'b0, 1'b1, 32'h0000_0100);
      cycle(1'b0, 1'b1, 1'b1, 32'h0000_0100);
      cycle(1'b0, 1'b1, 1'b1, 32'h0000_0200);
      cycle(1'b0, 1'b1, 1'b1, 32'h0000_0200);
      repeat (2) cycle(1'b0, 1'b1, 1'b0, 32'h0);

      // Simultaneous hazard and branch; then stall during SQUASH.
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_0300);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0);
      repeat (2) cycle(1'b0, 1'b1, 1'b0, 32'h0);

      // Reset mid-SQUASH.
      cycle(1'b0, 1'b1, 1'b1, 32'h0000_0080);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      mid_reset();
      repeat (2) cycle(1'b0, 1'b1, 1'b0, 32'h0);

      // Randomized traffic with an occasional mid-stream reset.
      for (int i = 0; i < 600; i++) begin
         if (i == 300) mid_reset();
         cycle(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 9) < 3), ($urandom() & 32'hFFFF_FFFC));
      end
      repeat (2) cycle(1'b0, 1'b1, 1'b0, 32'h0);

      @(negedge clk);
      @(negedge clk);
      if (expq.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain got=%0d want=0", expq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-redirect and pipeline-control unit: the producer of the fetch stage's `freeze`, `is_branch`, `flush` and `branch_address` inputs.
- Takes ID-stage hazard requests, memory-stage ready, and EXE-stage branch resolution.
- Turns them into a sequenced stall / redirect / squash protocol.
- Sits in the top-level core between the EXE/MEM stages and the fetch stage, replacing the tied-off control wires.

## Interface
Parameters:
- `ADDR_W`, 32 — branch target width; equals `LEN_ADDRESS`.
- `FLUSH_CYCLES`, 2 — total cycles `flush` is held per redirect; legal range 1..15.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — reset; asynchronous, active-high.
- `hazard`  in  1  — ID-stage data hazard; requests a fetch freeze.
- `mem_ready`  in  1  — memory stage ready; 0 stalls the whole pipeline.
- `exe_branch_taken`  in  1  — EXE resolved a taken branch this cycle.
- `exe_branch_address`  in  ADDR_W  — target for `exe_branch_taken`.
- `freeze`  out  1  — hold PC and IF/ID register (combinational).
- `is_branch`  out  1  — load PC from `branch_address` (registered).
- `flush`  out  1  — squash IF/ID and ID/EXE contents (registered).
- `branch_address`  out  ADDR_W  — redirect target (registered).
- `pending`  out  1  — a taken branch is captured but not yet issued.

## Operation
States are RUN, REDIRECT and SQUASH, plus a pending register (`pend_valid`, `pend_addr`) and a 4-bit squash counter.

- **RUN**
  - `freeze = hazard | ~mem_ready`; `is_branch = flush = 0`.
  - `exe_branch_taken=1` with `pend_valid=0` captures `exe_branch_address` into `pend_addr` and sets `pend_valid`.
  - When `pend_valid=1` and `mem_ready=1`: load `branch_address <= pend_addr`, clear `pend_valid`, go to REDIRECT. Capture and issue may occur on the same edge.
- **REDIRECT** (one cycle when `mem_ready=1`)
  - `is_branch=1`, `flush=1`.
  - `freeze = ~mem_ready`; `hazard` is ignored because the hazard instruction is wrong-path.
  - With `mem_ready=0`: stay in REDIRECT with all outputs held.
  - Next state is RUN if `FLUSH_CYCLES==1`, otherwise SQUASH with counter `= FLUSH_CYCLES-1`.
- **SQUASH**
  - `flush=1`, `is_branch=0`, `freeze = ~mem_ready`.
  - Counter decrements only when `mem_ready=1`; go to RUN when it reaches 1 and `mem_ready=1`.
- **While not in RUN:** `exe_branch_taken` is ignored (wrong-path branch) and never captured.
- **Pending register:**
  - A second `exe_branch_taken` while `pend_valid=1` is the same stalled branch held by EXE, so it is not re-captured and does not overwrite `pend_addr`.
  - `pending = pend_valid`.
- **`branch_address`:** holds its last value outside REDIRECT.

## Timing
- **Reset values** (asynchronous `rst`, also mid-operation): state RUN, `is_branch=0`, `flush=0`, `branch_address=0`, `pend_valid=0`, `pending=0`, counter 0. `freeze` then follows its RUN equation.
- **Redirect latency:** `exe_branch_taken` sampled at edge N with `mem_ready=1` gives `is_branch=flush=1` during cycle N+1. `flush` stays high through cycle N+`FLUSH_CYCLES`.
- **Stalled branch:** while `mem_ready=0`, the redirect waits. It issues on the cycle after the first edge that samples `mem_ready=1`.
- **`freeze` is combinational:**
  - `hazard` to `freeze` takes the same cycle.
  - `is_branch=1` with `freeze=0` occurs exactly once per redirect.
- **Simultaneous `hazard` and `exe_branch_taken` in RUN:**
  - `freeze=1` that cycle.
  - The redirect wins on the next cycle.

## Configuration
- **`FETCH_CTRL_STATS_EN` defined:** adds outputs `stall_cycles[15:0]` and `redirect_count[15:0]`.
  - Both are saturating counters (stop at 16'hFFFF) and reset to 0.
  - `stall_cycles` increments on every cycle with `freeze=1`.
  - `redirect_count` increments on every REDIRECT exit.
- **Undefined:** the ports and counters are absent. Control behaviour is identical either way.

## Test plan
- **Reset mid-SQUASH** (`FLUSH_CYCLES=2`): assert `rst` → `flush`, `is_branch`, `pending` go 0 immediately and `branch_address=0`. First cycle after release is RUN.
- **Branch in RUN:** `exe_branch_taken=1`, address 32'h0000_0040, `mem_ready=1` → next cycle `is_branch=1`, `flush=1`, `branch_address=32'h40`. Following cycle `flush=1`, `is_branch=0`, then RUN.
- **Hazard only:** `hazard=1` for 3 cycles → `freeze=1` in exactly those 3 cycles, `flush`/`is_branch` remain 0.
- **Branch during memory stall:** `mem_ready=0` for 4 cycles; `exe_branch_taken` held with 32'h100 → `pending=1` with no redirect and `freeze=1` throughout. One cycle after `mem_ready=1`, `is_branch=1` with 32'h100, issued once.
- **Wrong-path branch:** a second `exe_branch_taken` (32'h200) during SQUASH → ignored. `branch_address` stays 32'h100 and `pending` stays 0.
- **`FETCH_CTRL_STATS_EN`:** two redirects plus 5 stalled cycles → `redirect_count=2`, `stall_cycles` equals the observed count of `freeze=1` cycles.
